// File: rtl/accum_scan_engine.sv
// Reduction / inclusive prefix-scan engine over arr[lo, hi) with a granted host port.
// Optional ACCUM_SCAN_SAT_EN: saturating add for op=0 plus a sticky_ovf output.
module accum_scan_engine #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 1000,
    parameter int AW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r_enable,
    input  logic [AW-1:0]    init_lo,
    input  logic [AW-1:0]    init_hi,
    input  logic [WIDTH-1:0] init_acc,
    input  logic [1:0]       op,
    input  logic             mode_scan,
    input  logic             controlArr,
    output logic             controlArrReady,
    input  logic             controlArrWEnable_a,
    input  logic [AW-1:0]    controlArrAddr_a,
    input  logic [WIDTH-1:0] controlArrWData_a,
    output logic [WIDTH-1:0] controlArrRData_a,
    output logic             w_enable,
    output logic [WIDTH-1:0] result
`ifdef ACCUM_SCAN_SAT_EN
    ,
    output logic             sticky_ovf
`endif
);

    typedef enum logic [2:0] {IDLE, CHECK, READ, OPER, WRITE, DONE} state_t;

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    state_t            state_q, state_d;
    logic [AW-1:0]     i_q, i_d;
    logic [AW-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [1:0]        op_q, op_d;
    logic              scan_q, scan_d;
    logic              w_enable_q, w_enable_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  rd_data;
    logic              host_grant;
    logic [WIDTH-1:0]  op_res;

    assign rd_data           = mem[rd_addr_q];
    assign controlArrRData_a = rd_data;
    assign host_grant        = controlArr && !rst &&
                               (state_q == IDLE || state_q == CHECK || state_q == DONE);
    assign controlArrReady   = host_grant;
    assign w_enable          = w_enable_q;
    assign result            = result_q;

`ifdef ACCUM_SCAN_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic [WIDTH:0] sum_ext;
    logic           op_ovf;
    logic           sticky_q, sticky_d;
    assign sum_ext    = {acc_q[WIDTH-1], acc_q} + {rd_data[WIDTH-1], rd_data};
    assign sticky_ovf = sticky_q;
`endif

    // Operator datapath: combines the running accumulator with the word just read.
    always_comb begin
        op_res = acc_q;
`ifdef ACCUM_SCAN_SAT_EN
        op_ovf = 1'b0;
`endif
        case (op_q)
            2'd0: begin
`ifdef ACCUM_SCAN_SAT_EN
                // Sign of the extended sum disagreeing with bit WIDTH-1 means overflow.
                if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) begin
                    op_ovf = 1'b1;
                    op_res = sum_ext[WIDTH] ? SMIN : SMAX;
                end else begin
                    op_res = sum_ext[WIDTH-1:0];
                end
`else
                op_res = acc_q + rd_data;
`endif
            end
            2'd1: op_res = acc_q ^ rd_data;
            2'd2: op_res = ($signed(acc_q) > $signed(rd_data)) ? acc_q : rd_data;
            2'd3: op_res = ($signed(acc_q) < $signed(rd_data)) ? acc_q : rd_data;
            default: op_res = acc_q;
        endcase
    end

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        hi_d       = hi_q;
        acc_d      = acc_q;
        op_d       = op_q;
        scan_d     = scan_q;
        w_enable_d = w_enable_q;
        result_d   = result_q;
        rd_addr_d  = rd_addr_q;
        mem_we     = 1'b0;
        mem_waddr  = controlArrAddr_a;
        mem_wdata  = controlArrWData_a;
`ifdef ACCUM_SCAN_SAT_EN
        sticky_d   = sticky_q;
`endif

        if (host_grant) begin
            if (controlArrWEnable_a) mem_we = 1'b1;
            else                     rd_addr_d = controlArrAddr_a;
        end

        case (state_q)
            CHECK: begin
                if (!controlArr) state_d = (i_q >= hi_q) ? DONE : READ;
            end
            READ: begin
                rd_addr_d = i_q;
                state_d   = OPER;
            end
            OPER: begin
                acc_d = op_res;
`ifdef ACCUM_SCAN_SAT_EN
                sticky_d = sticky_q | op_ovf;
`endif
                if (scan_q) begin
                    state_d = WRITE;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = CHECK;
                end
            end
            WRITE: begin
                mem_we    = !r_enable;
                mem_waddr = i_q;
                mem_wdata = acc_q;
                i_d       = i_q + 1'b1;
                state_d   = CHECK;
            end
            DONE: begin
                result_d   = acc_q;
                w_enable_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = state_q;
        endcase

        // A start request restarts the engine from any state.
        if (r_enable) begin
            i_d        = init_lo;
            hi_d       = (init_hi > DEPTH_A) ? DEPTH_A : init_hi;
            acc_d      = init_acc;
            op_d       = op;
            scan_d     = mode_scan;
            w_enable_d = 1'b0;
            state_d    = CHECK;
`ifdef ACCUM_SCAN_SAT_EN
            sticky_d   = 1'b0;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            hi_q       <= '0;
            acc_q      <= '0;
            op_q       <= '0;
            scan_q     <= 1'b0;
            w_enable_q <= 1'b0;
            result_q   <= '0;
`ifdef ACCUM_SCAN_SAT_EN
            sticky_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            hi_q       <= hi_d;
            acc_q      <= acc_d;
            op_q       <= op_d;
            scan_q     <= scan_d;
            w_enable_q <= w_enable_d;
            result_q   <= result_d;
`ifdef ACCUM_SCAN_SAT_EN
            sticky_q   <= sticky_d;
`endif
        end
    end

    // NOTE: the array and its read-address register are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
        rd_addr_q <= rd_addr_d;
    end

endmodule

// File: doc/accum_scan_engine.md
Name: accum_scan_engine

Overview:
- Parametrised successor to the single-array accumulate kernel.
- Runs a reduction or an in-place inclusive prefix scan over an index range [lo, hi) of one on-chip array.
- Supports selectable operator, width and depth.
- Array loads and reads go through a host control port with a grant handshake. The top-level controller starts the engine with `r_enable` and collects the result when `w_enable` goes high.

Parameters:
- WIDTH, 64, data/accumulator width (signed).
- DEPTH, 1000, array entries.
- AW, $clog2(DEPTH+1), index width; must be able to represent DEPTH.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- r_enable  in  1  start; latches init_lo, init_hi, init_acc, op, mode_scan.
- init_lo  in  AW  first index.
- init_hi  in  AW  end index (exclusive).
- init_acc  in  WIDTH  accumulator seed.
- op  in  2  operator: 0 add, 1 xor, 2 signed max, 3 signed min.
- mode_scan  in  1  1 = write the running accumulator back to arr[i]; 0 = reduce only.
- controlArr  in  1  host requests the array port.
- controlArrReady  out  1  host access granted this cycle.
- controlArrWEnable_a  in  1  host write enable.
- controlArrAddr_a  in  AW  host address.
- controlArrWData_a  in  WIDTH  host write data.
- controlArrRData_a  out  WIDTH  host read data, valid the cycle after a granted read; X otherwise.
- w_enable  out  1  result valid; held high.
- result  out  WIDTH  final accumulator.

Behaviour:
- Reset (rst=1): state IDLE; w_enable=0; result=0; controlArrReady=0 on that cycle. Array contents are not cleared. rst beats r_enable in the same cycle.
- Memory: single port, synchronous write, 1-cycle read latency (registered read address). Address is a don't-care on a write cycle.
- FSM states: IDLE, CHECK, READ, OPER, WRITE, DONE.
  - r_enable in any state (rst=0): latch inputs; i=init_lo; acc=init_acc; w_enable=0; go to CHECK. This restarts any run in flight.
  - CHECK: if controlArr=1, stay. Else if i >= hi_eff, go to DONE. Else go to READ. hi_eff = min(init_hi, DEPTH).
  - READ: drive addr=i, read. Go to OPER.
  - OPER: acc <= op(acc, rdata). If mode_scan, go to WRITE; else i <= i+1 and go to CHECK.
  - WRITE: arr[i] <= acc; i <= i+1; go to CHECK.
  - DONE: result <= acc; w_enable <= 1; go to IDLE. w_enable stays 1 until the next r_enable or rst.
- Host grant: controlArrReady = controlArr && state in {IDLE, CHECK, DONE}. Host accesses are only performed when granted. The engine never drives the array on a granted cycle.
- Arithmetic: add wraps modulo 2^WIDTH; max/min are signed compares; xor is bitwise.
- Latency from the r_enable edge to w_enable high, with N = max(0, hi_eff − lo) and no host stalls:
  - reduce: 3N+3 cycles.
  - scan: 4N+3 cycles.
  - Each stalled CHECK cycle adds 1.
- Empty range (lo >= hi_eff): result = init_acc after 3 cycles; no array writes.
- Reset mid-run: aborts immediately. Array writes already committed persist.

Optional Feature:
- Macro ACCUM_SCAN_SAT_EN.
  - Defined: op=0 uses signed saturating add, clamping to +(2^(WIDTH−1)−1) / −2^(WIDTH−1). Adds output sticky_ovf (1 bit), which is cleared on r_enable and rst and set on any clamp.
  - Undefined: add wraps; no sticky_ovf port.

Test Plan:
- Load arr[0..3]={1,2,3,4} via host, then r_enable with lo=0, hi=4, acc=10, op=0, scan=0 -> result=20; w_enable high at cycle 15; arr unchanged.
- Same load, scan=1 -> arr[0..3]={11,13,16,20}; result=20; w_enable high at cycle 19.
- op=2 over {−5,7,−9}, acc=−100 -> result=7. op=3 -> result=−100.
- lo=5, hi=5, acc=42 -> result=42 at cycle 3. hi=1200 with DEPTH=1000 is clamped to 1000.
- Hold controlArr during CHECK for 4 cycles mid-run; host read of arr[1] -> controlArrReady=1 and rdata is correct; engine latency +4 and result unchanged. controlArr held during READ -> controlArrReady=0.
- rst at cycle 6 of a scan run -> w_enable=0, result=0, state IDLE; next run from r_enable completes normally. With the macro defined: acc=2^62, arr={2^62, 2^62} -> result=2^63−1 and sticky_ovf=1.
